// File: rtl/pipeline_ctrl.sv
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             br_taken,
  input  logic [63:0]      br_target,
  input  logic             mem_busy,
  output logic             addr_sel,
  output logic [63:0]      target_out,
  output logic             flush,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             id_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSHING = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        fcnt, fcnt_nx;
  logic              pend_valid, pend_valid_nx;
  logic [63:0]       pend_addr, pend_addr_nx;
  logic [63:0]       tgt_q;
  logic [CNT_W-1:0]  stall_q, redir_q;
  logic              stall_inc, redir_inc;

  logic              lu, br_eff;
  logic [63:0]       tgt;
  logic              a_sel, fl, fe_hold, bub, p_hold;

  assign lu = ex_mem_read && (ex_rd != 5'd31) &&
              ((id_uses_rn && (id_rn == ex_rd)) ||
               (id_uses_rm && (id_rm == ex_rd)));
  assign br_eff = br_taken || pend_valid;
  assign tgt    = pend_valid ? pend_addr : br_target;

  always_comb begin
    state_nx      = state;
    fcnt_nx       = fcnt;
    pend_valid_nx = pend_valid;
    pend_addr_nx  = pend_addr;
    a_sel         = 1'b0;
    fl            = 1'b0;
    fe_hold       = 1'b0;
    bub           = 1'b0;
    p_hold        = 1'b0;
    stall_inc     = 1'b0;
    redir_inc     = 1'b0;

    if (mem_busy) begin
      // fcnt is left untouched so an interrupted flush resumes after the wait
      fe_hold   = 1'b1;
      p_hold    = 1'b1;
      stall_inc = 1'b1;
      state_nx  = MEM_WAIT;
      if (br_taken && !pend_valid) begin
        pend_valid_nx = 1'b1;
        pend_addr_nx  = br_target;
      end
    end else if (br_eff) begin
      a_sel         = 1'b1;
      fl            = 1'b1;
      redir_inc     = 1'b1;
      pend_valid_nx = 1'b0;
      fcnt_nx       = 2'(FLUSH_CYCLES);
      state_nx      = (FLUSH_CYCLES > 0) ? FLUSHING : RUN;
    end else begin
      case (state)
        RUN: begin
          if (lu) begin
            fe_hold   = 1'b1;
            bub       = 1'b1;
            stall_inc = 1'b1;
            state_nx  = LU_STALL;
          end
        end
        LU_STALL: state_nx = RUN;
        FLUSHING: begin
          fl = 1'b1;
          if (fcnt <= 2'd1) begin
            fcnt_nx  = 2'd0;
            state_nx = RUN;
          end else begin
            fcnt_nx = fcnt - 2'd1;
          end
        end
        MEM_WAIT: state_nx = (fcnt != 2'd0) ? FLUSHING : RUN;
        default:  state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      fcnt       <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      tgt_q      <= '0;
      stall_q    <= '0;
      redir_q    <= '0;
    end else begin
      state      <= state_nx;
      fcnt       <= fcnt_nx;
      pend_valid <= pend_valid_nx;
      pend_addr  <= pend_addr_nx;
      if (a_sel)     tgt_q   <= tgt;
      if (stall_inc) stall_q <= stall_q + CNT_W'(1);
      if (redir_inc) redir_q <= redir_q + CNT_W'(1);
    end
  end

  // All outputs are forced low while reset is asserted, before the reset edge lands
  assign addr_sel     = reset & a_sel;
  assign flush        = reset & fl;
  assign pc_hold      = reset & fe_hold;
  assign ifid_hold    = reset & fe_hold;
  assign id_bubble    = reset & bub;
  assign pipe_hold    = reset & p_hold;
  assign target_out   = !reset ? '0 : (a_sel ? tgt : tgt_q);
  assign stall_cnt    = reset ? stall_q : '0;
  assign redirect_cnt = reset ? redir_q : '0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rn, id_uses_rm, ex_mem_read;
  logic        br_taken, mem_busy;
  logic [63:0] br_target;

  logic        addr_sel, flush, pc_hold, ifid_hold, id_bubble, pipe_hold;
  logic [63:0] target_out;
  logic [31:0] stall_cnt, redirect_cnt;

  logic        addr_sel2, flush2, pc_hold2, ifid_hold2, id_bubble2, pipe_hold2;
  logic [63:0] target_out2;
  logic [3:0]  stall_cnt2, redirect_cnt2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pipeline_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .br_taken(br_taken), .br_target(br_target), .mem_busy(mem_busy),
    .addr_sel(addr_sel), .target_out(target_out), .flush(flush),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .id_bubble(id_bubble), .pipe_hold(pipe_hold),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .br_taken(br_taken), .br_target(br_target), .mem_busy(mem_busy),
    .addr_sel(addr_sel2), .target_out(target_out2), .flush(flush2),
    .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .id_bubble(id_bubble2), .pipe_hold(pipe_hold2),
    .stall_cnt(stall_cnt2), .redirect_cnt(redirect_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    id_rn = '0; id_rm = '0; ex_rd = '0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_mem_read = 1'b0;
    br_taken = 1'b0; br_target = '0; mem_busy = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rn = rd; id_uses_rn = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    // Reset masks outputs even with a branch and a busy request present
    br_taken = 1'b1; br_target = 64'h1234; mem_busy = 1'b1;
    settle();
    check("rst_addr_sel", addr_sel, 0);
    check("rst_pipe_hold", pipe_hold, 0);
    check("rst_target", target_out, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_redir", redirect_cnt, 0);
    tick();
    clear_inputs();
    reset = 1'b1;

    // Load-use on rn
    set_lu(5'd3);
    settle();
    check("lu_pc_hold", pc_hold, 1);
    check("lu_ifid_hold", ifid_hold, 1);
    check("lu_bubble", id_bubble, 1);
    check("lu_pipe_hold", pipe_hold, 0);
    check("lu_flush", flush, 0);
    tick();
    settle();
    check("lu_stall_state_bubble", id_bubble, 0);
    check("lu_stall_state_hold", pc_hold, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    clear_inputs();
    tick();
    // XZR never hazards
    set_lu(5'd31);
    settle();
    check("xzr_bubble", id_bubble, 0);
    check("xzr_hold", pc_hold, 0);
    // Matching rn with use flag clear
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rn = 5'd9; id_uses_rn = 1'b0;
    settle();
    check("unused_rn_bubble", id_bubble, 0);
    // Load-use on rm
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; id_uses_rm = 1'b1;
    settle();
    check("lu_rm_bubble", id_bubble, 1);
    tick();
    clear_inputs();
    tick();
    check("lu_rm_stall_cnt", stall_cnt, 2);

    // Taken branch; dut has one extra flush cycle, dut2 has two
    reset_dut();
    br_taken = 1'b1; br_target = 64'h400;
    settle();
    check("br_addr_sel", addr_sel, 1);
    check("br_target", target_out, 64'h400);
    check("br_flush", flush, 1);
    check("br_no_hold", pc_hold, 0);
    tick();
    br_taken = 1'b0; br_target = 64'h999;
    settle();
    check("fl1_flush", flush, 1);
    check("fl1_addr_sel", addr_sel, 0);
    check("fl1_target_held", target_out, 64'h400);
    check("fl1_redir", redirect_cnt, 1);
    check("fl1_flush2", flush2, 1);
    tick();
    settle();
    check("fl2_flush", flush, 0);
    check("fl2_flush2", flush2, 1);
    tick();
    settle();
    check("fl3_flush2", flush2, 0);
    check("fl3_redir2", redirect_cnt2, 1);

    // Branch arriving in the middle of a 3-cycle memory wait
    reset_dut();
    mem_busy = 1'b1;
    settle();
    check("mw1_pc_hold", pc_hold, 1);
    check("mw1_ifid_hold", ifid_hold, 1);
    check("mw1_pipe_hold", pipe_hold, 1);
    tick();
    br_taken = 1'b1; br_target = 64'h80;
    settle();
    check("mw2_addr_sel", addr_sel, 0);
    check("mw2_flush", flush, 0);
    check("mw2_pipe_hold", pipe_hold, 1);
    tick();
    br_taken = 1'b0; br_target = 64'h0;
    settle();
    check("mw3_addr_sel", addr_sel, 0);
    check("mw3_pipe_hold", pipe_hold, 1);
    tick();
    mem_busy = 1'b0;
    settle();
    check("mw_exit_addr_sel", addr_sel, 1);
    check("mw_exit_target", target_out, 64'h80);
    check("mw_exit_flush", flush, 1);
    check("mw_exit_hold", pipe_hold, 0);
    check("mw_stall_cnt", stall_cnt, 3);
    tick();
    settle();
    check("mw_redir", redirect_cnt, 1);
    check("mw_after_flush", flush, 1);
    check("mw_after_addr_sel", addr_sel, 0);
    tick();

    // Branch and load-use together: branch wins
    reset_dut();
    set_lu(5'd5);
    br_taken = 1'b1; br_target = 64'h1234;
    settle();
    check("brlu_addr_sel", addr_sel, 1);
    check("brlu_bubble", id_bubble, 0);
    check("brlu_hold", pc_hold, 0);
    tick();
    clear_inputs();
    settle();
    check("brlu_stall_cnt", stall_cnt, 0);
    check("brlu_redir", redirect_cnt, 1);
    tick();

    // Reset with a branch pending behind an interrupted flush
    reset_dut();
    br_taken = 1'b1; br_target = 64'h500;
    tick();
    mem_busy = 1'b1; br_target = 64'h600;
    tick();
    reset = 1'b0;
    settle();
    check("rmid_masked_hold", pipe_hold, 0);
    tick();
    settle();
    check("rmid_pc_hold", pc_hold, 0);
    check("rmid_target", target_out, 0);
    check("rmid_stall", stall_cnt, 0);
    check("rmid_redir", redirect_cnt, 0);
    clear_inputs();
    reset = 1'b1;
    settle();
    check("rmid_post_addr_sel", addr_sel, 0);
    check("rmid_post_flush", flush, 0);
    tick();
    settle();
    check("rmid_post_redir", redirect_cnt, 0);
    check("rmid_post_target", target_out, 0);

    // 17 load-use stalls: 4-bit counter wraps to 1
    reset_dut();
    set_lu(5'd12);
    for (int i = 0; i < 34; i++) tick();
    clear_inputs();
    settle();
    check("wrap_stall32", stall_cnt, 17);
    check("wrap_stall4", stall_cnt2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipelined CPU. Drives the instruction fetch stage's `addr_sel_in`, `flush` and target address, and the pipeline hold and bubble controls. It resolves load-use hazards, taken-branch redirects and data-memory wait states. A branch that arrives during a memory wait is latched and replayed when the wait ends.

## Interface
- `FLUSH_CYCLES`, default 1: extra cycles `flush` stays high after the redirect cycle (range 0–3).
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `id_rn`, `id_rm`  in  5 each  source registers of the instruction in ID.
- `id_uses_rn`, `id_uses_rm`  in  1 each  source valid flags.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_rd`  in  5  destination register of that load.
- `br_taken`  in  1  branch resolved taken this cycle.
- `br_target`  in  64  branch target address.
- `mem_busy`  in  1  data memory not ready; the whole pipeline must hold.
- `addr_sel`  out  1  to IF `addr_sel_in`; 1 selects `target_out`.
- `target_out`  out  64  to IF `addr_IF_in`.
- `flush`  out  1  to IF `flush`; turns the fetched instruction into a noop.
- `pc_hold`, `ifid_hold`  out  1 each  freeze PC and IF/ID.
- `id_bubble`  out  1  insert a noop into ID/EX.
- `pipe_hold`  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- `stall_cnt`, `redirect_cnt`  out  `CNT_W` each  performance counters.

## Operation
The FSM has 4 states: RUN, LU_STALL, FLUSHING, MEM_WAIT.

Detection terms (combinational):
- Load-use, `lu`: `ex_mem_read` AND `ex_rd != 31` AND a source match. A source matches when (`id_uses_rn` AND `id_rn == ex_rd`) or (`id_uses_rm` AND `id_rm == ex_rd`). X31 (XZR) never hazards.
- `br_eff` = `br_taken` OR `pend_valid`.
- `tgt` = `pend_addr` if `pend_valid`, else `br_target`.

Priority each cycle is `mem_busy` > branch > load-use.

- **`mem_busy` = 1, any state:**
  - Outputs: `pc_hold` = `ifid_hold` = `pipe_hold` = 1; `addr_sel` = 0; `flush` = 0.
  - If `br_taken` arrives and `pend_valid` = 0, latch `pend_addr` <= `br_target` and set `pend_valid` <= 1. A second `br_taken` while a branch is pending is ignored.
  - Next state: MEM_WAIT. `stall_cnt` += 1.
- **Branch (`mem_busy` = 0, `br_eff` = 1):**
  - Outputs: `addr_sel` = 1, `target_out` = `tgt`, `flush` = 1; no holds; the load-use term is ignored.
  - Clear `pend_valid`. Load `fcnt` <= `FLUSH_CYCLES`. `redirect_cnt` += 1.
  - Next state: FLUSHING if `FLUSH_CYCLES` > 0, else RUN.
- **FLUSHING:** `flush` = 1, `addr_sel` = 0. `fcnt` decrements each cycle; go to RUN when it reaches 1. A new `br_taken` restarts the redirect (branch rule). `mem_busy` suspends the flush: `fcnt` freezes, and the state returns to FLUSHING after MEM_WAIT.
- **Load-use (RUN, no branch, no busy):**
  - Outputs: `pc_hold` = `ifid_hold` = `id_bubble` = 1 for exactly 1 cycle. `stall_cnt` += 1.
  - Next state: LU_STALL. LU_STALL always returns to RUN next cycle and does not re-detect on the same pair (EX now holds the bubble).
- **MEM_WAIT:** leaves when `mem_busy` = 0. In that same cycle the pending branch, if any, is applied per the branch rule; otherwise the state returns to RUN, or to FLUSHING when `fcnt` > 0.
- `target_out` equals `tgt` whenever `addr_sel` = 1. Otherwise it holds its last driven value (registered copy).
- Counters wrap at 2^`CNT_W` with no saturation.

## Timing
- All control outputs are combinational from state and inputs in the same cycle, so IF sees `addr_sel`/`flush` in the cycle the branch resolves.
- Registered state: FSM, `fcnt`, `pend_valid`, `pend_addr`, `target_out` copy, counters.
- Reset (`reset` = 0 at a rising edge): state RUN, `pend_valid` = 0, `pend_addr` = 0, `fcnt` = 0, counters = 0, `target_out` = 0. While in reset all outputs read 0. Reset mid-stall or mid-flush discards the pending branch.
- Redirect latency: 0 cycles from `br_taken` (or from `mem_busy` falling with a branch pending) to `addr_sel` = 1.
- Load-use costs exactly 1 bubble cycle; a branch costs 1 + `FLUSH_CYCLES` flushed fetches.
- Simultaneous `br_taken` and `lu` in RUN: branch wins, no bubble.

## Test plan
- **Load-use:** `ex_mem_read` = 1, `ex_rd` = 3, `id_rn` = 3, `id_uses_rn` = 1 → 1 cycle of `pc_hold` = `ifid_hold` = `id_bubble` = 1, then all 0; `stall_cnt` = 1. The same case with `ex_rd` = 31 gives no stall.
- **Branch, `FLUSH_CYCLES` = 1:** `br_taken` with `br_target` = 0x400 → `addr_sel` = 1, `target_out` = 0x400, `flush` = 1 in that cycle; `flush` = 1 in the next cycle with `addr_sel` = 0; then RUN; `redirect_cnt` = 1.
- **Branch during wait:** `mem_busy` high for 3 cycles, `br_taken` (target 0x80) in the 2nd → holds for 3 cycles with `addr_sel` = 0; in the cycle `mem_busy` falls, `addr_sel` = 1 and `target_out` = 0x80; `stall_cnt` = 3.
- **Branch plus load-use:** `br_taken` and `lu` in the same cycle → `addr_sel` = 1, `id_bubble` = 0, `stall_cnt` unchanged.
- **Reset mid-flush:** `reset` = 0 during FLUSHING with a pending branch → next cycle all outputs are 0 and counters are 0; after release, `br_taken` = 0 produces no redirect.
- **Wrap-around:** with `CNT_W` = 4, 17 load-use stalls → `stall_cnt` = 1.
